// File: rtl/decode_stage_pkg.sv
// Shared ISA constants for the decode stage: instruction field positions, opcodes, ALU codes.
// Field positions describe the 16-bit instruction format; MODE bit is the MSB.
package decode_stage_pkg;

    localparam int INSTR_MODE = 15;
    localparam logic MODE_REG = 1'b0;
    localparam logic MODE_DAT = 1'b1;

    // MSB positions of each field; slices are taken with -: and the field width
    localparam int R1LOC_REG  = 14;
    localparam int R2LOC_REG  = 11;
    localparam int R1LOC_DAT  = 14;
    localparam int OPCODE_REG = 4;
    localparam int OPCODE_W   = 5;

    typedef enum logic [OPCODE_W-1:0] {
        OPR_ADD    = 5'd0,
        OPR_AND    = 5'd1,
        OPR_SUB    = 5'd2,
        OPR_OR     = 5'd3,
        OPR_XOR    = 5'd4,
        OPR_ADC    = 5'd5,
        OPR_NOT    = 5'd6,
        OPR_SAR    = 5'd7,
        OPR_SLR    = 5'd8,
        OPR_SAL    = 5'd9,
        OPR_SLL    = 5'd10,
        OPR_ROL    = 5'd11,
        OPR_ROR    = 5'd12,
        OPR_MOV    = 5'd13,
        OPR_SHOWR  = 5'd14,
        OPR_SHOWRR = 5'd15
    } opr_e;

    typedef enum logic [3:0] {
        ALUOP_PD1 = 4'd0,
        ALUOP_PD2 = 4'd1,
        ALUOP_ADD = 4'd2,
        ALUOP_AND = 4'd3,
        ALUOP_SUB = 4'd4,
        ALUOP_OR  = 4'd5,
        ALUOP_XOR = 4'd6,
        ALUOP_ADC = 4'd7,
        ALUOP_NOT = 4'd8,
        ALUOP_SAR = 4'd9,
        ALUOP_SLR = 4'd10,
        ALUOP_SAL = 4'd11,
        ALUOP_SLL = 4'd12,
        ALUOP_ROL = 4'd13,
        ALUOP_ROR = 4'd14
    } aluop_e;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } fifo_cnt_e;

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction-to-controls mapping for the decode stage.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int ALUOP_W = 4,
    parameter int IMM_W   = 8
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  addr_reg1,
    output logic [REG_AW-1:0]  addr_reg2,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               write_back,
    output logic               show_r1,
    output logic               show_r2,
    output logic               imm_valid,
    output logic               illegal,
    output logic [IMM_W-1:0]   imm
);

    logic [OPCODE_W-1:0] opcode;
    logic                unused_instr;

    assign opcode       = instr[OPCODE_REG -: OPCODE_W];
    assign unused_instr = ^instr;

    always_comb begin
        addr_reg1  = '0;
        addr_reg2  = '0;
        alu_op     = ALUOP_W'(ALUOP_PD1);
        write_back = 1'b0;
        show_r1    = 1'b0;
        show_r2    = 1'b0;
        imm_valid  = 1'b0;
        illegal    = 1'b0;
        imm        = '0;
        if (instr[INSTR_MODE] == MODE_DAT) begin
            addr_reg1  = instr[R1LOC_DAT -: REG_AW];
            imm        = instr[IMM_W-1:0];
            imm_valid  = 1'b1;
            alu_op     = ALUOP_W'(ALUOP_PD2);
            write_back = 1'b1;
        end else begin
            addr_reg1  = instr[R1LOC_REG -: REG_AW];
            addr_reg2  = instr[R2LOC_REG -: REG_AW];
            write_back = 1'b1;
            case (opcode)
                OPR_ADD: alu_op = ALUOP_W'(ALUOP_ADD);
                OPR_AND: alu_op = ALUOP_W'(ALUOP_AND);
                OPR_SUB: alu_op = ALUOP_W'(ALUOP_SUB);
                OPR_OR:  alu_op = ALUOP_W'(ALUOP_OR);
                OPR_XOR: alu_op = ALUOP_W'(ALUOP_XOR);
                OPR_ADC: alu_op = ALUOP_W'(ALUOP_ADC);
                OPR_NOT: alu_op = ALUOP_W'(ALUOP_NOT);
                OPR_SAR: alu_op = ALUOP_W'(ALUOP_SAR);
                OPR_SLR: alu_op = ALUOP_W'(ALUOP_SLR);
                OPR_SAL: alu_op = ALUOP_W'(ALUOP_SAL);
                OPR_SLL: alu_op = ALUOP_W'(ALUOP_SLL);
                OPR_ROL: alu_op = ALUOP_W'(ALUOP_ROL);
                OPR_ROR: alu_op = ALUOP_W'(ALUOP_ROR);
                OPR_MOV: alu_op = ALUOP_W'(ALUOP_PD2);
                OPR_SHOWRR: begin
                    write_back = 1'b0;
                    show_r1    = 1'b1;
                    show_r2    = 1'b1;
                end
                OPR_SHOWR: begin
                    write_back = 1'b0;
                    show_r1    = 1'b1;
                end
                default: begin
                    write_back = 1'b0;
                    illegal    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes at accept time into a 2-entry FIFO with valid/ready handshakes.
// Optional DECODE_PERFCNT_EN adds o_DecCount, a wrapping count of accepted instructions.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int ALUOP_W = 4,
    parameter int IMM_W   = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_InstrValid,
    output logic               o_InstrReady,
    input  logic [INSTR_W-1:0] i_Instr,
    input  logic               i_Flush,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic [REG_AW-1:0]  o_AddrReg1,
    output logic [REG_AW-1:0]  o_AddrReg2,
    output logic [ALUOP_W-1:0] o_ALUOp,
    output logic               o_WriteBack,
    output logic               o_ShowR1,
    output logic               o_ShowR2,
    output logic               o_ImmValid,
    output logic               o_Illegal,
`ifdef DECODE_PERFCNT_EN
    output logic [15:0]        o_DecCount,
`endif
    output logic [IMM_W-1:0]   o_Imm
);

    localparam int ENTRY_W = 2*REG_AW + ALUOP_W + 5 + IMM_W;

    logic [REG_AW-1:0]  dec_addr1, dec_addr2;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_wb, dec_s1, dec_s2, dec_iv, dec_il;
    logic [IMM_W-1:0]   dec_imm;
    logic [ENTRY_W-1:0] dec_entry;

    decode_logic #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW),
        .ALUOP_W (ALUOP_W),
        .IMM_W   (IMM_W)
    ) u_decode_logic (
        .instr      (i_Instr),
        .addr_reg1  (dec_addr1),
        .addr_reg2  (dec_addr2),
        .alu_op     (dec_alu_op),
        .write_back (dec_wb),
        .show_r1    (dec_s1),
        .show_r2    (dec_s2),
        .imm_valid  (dec_iv),
        .illegal    (dec_il),
        .imm        (dec_imm)
    );

    assign dec_entry = {dec_addr1, dec_addr2, dec_alu_op, dec_wb, dec_s1, dec_s2,
                        dec_iv, dec_il, dec_imm};

    logic [ENTRY_W-1:0] mem_reg [2];
    logic               rd_ptr_reg, wr_ptr_reg;
    fifo_cnt_e          count_reg, count_next;
    logic               ready_reg;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;

    assign push = i_InstrValid && ready_reg && !i_Flush;
    assign pop  = (count_reg != CNT_EMPTY) && i_Ready && !i_Flush;

    always_comb begin
        count_next = count_reg;
        if (i_Flush) begin
            count_next = CNT_EMPTY;
        end else if (push && !pop) begin
            count_next = fifo_cnt_e'(count_reg + 2'd1);
        end else if (pop && !push) begin
            count_next = fifo_cnt_e'(count_reg - 2'd1);
        end
    end

    // Ready is registered from the next count, so a pop in FULL cannot admit a same-edge push
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            count_reg  <= CNT_EMPTY;
            ready_reg  <= 1'b0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            ready_reg <= (count_next != CNT_FULL);
            if (i_Flush) begin
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= 1'b0;
            end else begin
                if (push) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Storage needs no reset: contents are masked whenever the FIFO is empty
    always_ff @(posedge i_Clk) begin
        if (push) mem_reg[wr_ptr_reg] <= dec_entry;
    end

    assign o_Valid      = (count_reg != CNT_EMPTY);
    assign o_InstrReady = ready_reg;
    assign head         = o_Valid ? mem_reg[rd_ptr_reg] : '0;
    assign {o_AddrReg1, o_AddrReg2, o_ALUOp, o_WriteBack, o_ShowR1, o_ShowR2,
            o_ImmValid, o_Illegal, o_Imm} = head;

`ifdef DECODE_PERFCNT_EN
    logic [15:0] dec_count_reg;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            dec_count_reg <= 16'h0000;
        end else if (push) begin
            dec_count_reg <= dec_count_reg + 16'h0001;
        end
    end

    assign o_DecCount = dec_count_reg;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven self-checking bench for decode_stage.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [2:0]  addr1, addr2;
    logic [3:0]  alu_op;
    logic        wb, s1, s2, iv, il;
    logic [7:0]  imm;
`ifdef DECODE_PERFCNT_EN
    logic [15:0] dec_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    decode_stage dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_InstrValid (instr_valid),
        .o_InstrReady (instr_ready),
        .i_Instr      (instr),
        .i_Flush      (flush),
        .o_Valid      (valid),
        .i_Ready      (ready),
        .o_AddrReg1   (addr1),
        .o_AddrReg2   (addr2),
        .o_ALUOp      (alu_op),
        .o_WriteBack  (wb),
        .o_ShowR1     (s1),
        .o_ShowR2     (s2),
        .o_ImmValid   (iv),
        .o_Illegal    (il),
`ifdef DECODE_PERFCNT_EN
        .o_DecCount   (dec_count),
`endif
        .o_Imm        (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [15:0] instr;
        logic [2:0] a1, a2;
        logic [3:0] op;
        logic       wb, s1, s2, iv, il;
        logic [7:0] imm;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [15:0] mk_reg(input logic [2:0] r1, input logic [2:0] r2,
                                           input logic [4:0] op);
        return {1'b0, r1, r2, 4'b0000, op};
    endfunction

    function automatic logic [15:0] mk_dat(input logic [2:0] r1, input logic [7:0] v);
        return {1'b1, r1, 4'hF, v};
    endfunction

    function automatic logic [26:0] outs();
        return {valid, addr1, addr2, alu_op, wb, s1, s2, iv, il, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [15:0] w);
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"add_r2_r5",  mk_reg(3'd2, 3'd5, 5'd0),  3'd2, 3'd5, ALUOP_ADD, 1, 0, 0, 0, 0, 8'h00};
        vecs[1]  = '{"dat_r3_a7",  mk_dat(3'd3, 8'hA7),       3'd3, 3'd0, ALUOP_PD2, 1, 0, 0, 1, 0, 8'hA7};
        vecs[2]  = '{"sub_r7_r0",  mk_reg(3'd7, 3'd0, 5'd2),  3'd7, 3'd0, ALUOP_SUB, 1, 0, 0, 0, 0, 8'h00};
        vecs[3]  = '{"ror_r1_r6",  mk_reg(3'd1, 3'd6, 5'd12), 3'd1, 3'd6, ALUOP_ROR, 1, 0, 0, 0, 0, 8'h00};
        vecs[4]  = '{"mov_r4_r3",  mk_reg(3'd4, 3'd3, 5'd13), 3'd4, 3'd3, ALUOP_PD2, 1, 0, 0, 0, 0, 8'h00};
        vecs[5]  = '{"showrr",     mk_reg(3'd6, 3'd1, 5'd15), 3'd6, 3'd1, ALUOP_PD1, 0, 1, 1, 0, 0, 8'h00};
        vecs[6]  = '{"showr",      mk_reg(3'd5, 3'd2, 5'd14), 3'd5, 3'd2, ALUOP_PD1, 0, 1, 0, 0, 0, 8'h00};
        vecs[7]  = '{"illegal_1f", mk_reg(3'd1, 3'd1, 5'd31), 3'd1, 3'd1, ALUOP_PD1, 0, 0, 0, 0, 1, 8'h00};
        vecs[8]  = '{"xor_r0_r7",  mk_reg(3'd0, 3'd7, 5'd4),  3'd0, 3'd7, ALUOP_XOR, 1, 0, 0, 0, 0, 8'h00};
        vecs[9]  = '{"not_r3_r3",  mk_reg(3'd3, 3'd3, 5'd6),  3'd3, 3'd3, ALUOP_NOT, 1, 0, 0, 0, 0, 8'h00};
        vecs[10] = '{"sal_r2_r1",  mk_reg(3'd2, 3'd1, 5'd9),  3'd2, 3'd1, ALUOP_SAL, 1, 0, 0, 0, 0, 8'h00};
        vecs[11] = '{"illegal_10", mk_reg(3'd7, 3'd7, 5'd16), 3'd7, 3'd7, ALUOP_PD1, 0, 0, 0, 0, 1, 8'h00};

        // Reset with an instruction in flight
        rst_n = 1'b0; flush = 1'b0; ready = 1'b1;
        instr_valid = 1'b1; instr = mk_reg(3'd1, 3'd2, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_ready", 32'(instr_ready), 32'd0);
        check("reset_outs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(instr_ready), 32'd1);
        check("inflight_lost", 32'(valid), 32'd0);
        instr_valid = 1'b0;

        // Back-to-back stream with i_Ready high: each word visible one edge after accept
        for (int i = 0; i < 12; i++) begin
            push_one(vecs[i].instr);
            $display("[TB] vec %s instr=0x%04h outs=0x%07h", vecs[i].name, vecs[i].instr, outs());
            check(vecs[i].name, 32'(outs()),
                  32'({1'b1, vecs[i].a1, vecs[i].a2, vecs[i].op, vecs[i].wb, vecs[i].s1,
                       vecs[i].s2, vecs[i].iv, vecs[i].il, vecs[i].imm}));
        end
        @(posedge clk); #1;
        check("empty_outs_zero", 32'(outs()), 32'd0);

        // Backpressure: fill, stall third, then drain in order
        ready = 1'b0;
        push_one(mk_reg(3'd1, 3'd2, 5'd0));
        check("bp_ready_one", 32'(instr_ready), 32'd1);
        push_one(mk_reg(3'd3, 3'd4, 5'd2));
        check("bp_ready_full", 32'(instr_ready), 32'd0);
        instr_valid = 1'b1; instr = mk_reg(3'd5, 3'd6, 5'd3);
        @(posedge clk); #1;
        check("bp_head_stable", 32'({valid, addr1, alu_op}), 32'({1'b1, 3'd1, ALUOP_ADD}));
        ready = 1'b1;
        @(posedge clk); #1;
        $display("[TB] drain entry 2 addr1=%0d aluop=%0d", addr1, alu_op);
        check("bp_second", 32'({valid, addr1, alu_op}), 32'({1'b1, 3'd3, ALUOP_SUB}));
        @(posedge clk); #1;
        instr_valid = 1'b0;
        $display("[TB] drain entry 3 addr1=%0d aluop=%0d", addr1, alu_op);
        check("bp_third", 32'({valid, addr1, alu_op}), 32'({1'b1, 3'd5, ALUOP_OR}));
        @(posedge clk); #1;
        check("bp_drained", 32'(valid), 32'd0);

        // Flush in FULL with a push offered
        ready = 1'b0;
        push_one(mk_reg(3'd1, 3'd1, 5'd1));
        push_one(mk_reg(3'd2, 3'd2, 5'd1));
        flush = 1'b1; instr_valid = 1'b1; instr = mk_dat(3'd7, 8'h55);
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        $display("[TB] flush full valid=%0d ready=%0d", valid, instr_ready);
        check("flush_full_valid", 32'({valid, instr_ready}), 32'({1'b0, 1'b1}));
        @(posedge clk); #1;
        check("flush_full_discard", 32'(valid), 32'd0);

        // Flush in ONE overrides an acceptable push and a pop
        ready = 1'b1;
        push_one(mk_reg(3'd4, 3'd4, 5'd0));
        flush = 1'b1; instr_valid = 1'b1; instr = mk_dat(3'd6, 8'h11);
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        check("flush_one_push", 32'(valid), 32'd0);
        push_one(mk_dat(3'd6, 8'h22));
        check("post_flush_push", 32'({valid, addr1, imm}), 32'({1'b1, 3'd6, 8'h22}));
        @(posedge clk); #1;

        // Asynchronous reset clears outputs without a clock edge
        ready = 1'b0;
        push_one(mk_reg(3'd3, 3'd5, 5'd0));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({valid, instr_ready, outs()}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef DECODE_PERFCNT_EN
        check("perf_after_reset", 32'(dec_count), 32'd0);
        ready = 1'b1; instr_valid = 1'b1; instr = mk_reg(3'd1, 3'd2, 5'd0);
        repeat (65534) @(posedge clk);
        #1;
        check("perf_fffe", 32'(dec_count), 32'h0000FFFE);
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] perf counter after wrap = 0x%04h", dec_count);
        check("perf_wrap", 32'(dec_count), 32'h00000001);
        #2 rst_n = 1'b0;
        #1;
        check("perf_reset", 32'(dec_count), 32'd0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-002 SHALL have parameter REG_AW, default 3, register-address width.
REQ-003 SHALL have parameter ALUOP_W, default 4, ALU-operation code width.
REQ-004 SHALL have parameter IMM_W, default 8, immediate width (IMM_W <= INSTR_W-1-REG_AW).
REQ-005 SHALL have ports as follows. One clock, i_Clk; reset is asynchronous and active-low, i_Rst_n.
- i_Clk  in  1  clock
- i_Rst_n  in  1  async active-low reset
- i_InstrValid  in  1  upstream instruction valid
- o_InstrReady  out  1  decoder can accept
- i_Instr  in  INSTR_W  instruction word
- i_Flush  in  1  discard all queued decodes
- o_Valid  out  1  decoded entry at head valid
- i_Ready  in  1  downstream accepts head
- o_AddrReg1, o_AddrReg2  out  REG_AW  register addresses
- o_ALUOp  out  ALUOP_W  ALU operation
- o_WriteBack, o_ShowR1, o_ShowR2, o_ImmValid, o_Illegal  out  1  control flags
- o_Imm  out  IMM_W  immediate

Function
REQ-006 SHALL accept an instruction on a rising i_Clk edge where i_InstrValid && o_InstrReady && !i_Flush.
REQ-007 SHALL pop the head entry on an edge where o_Valid && i_Ready.
REQ-008 SHALL hold decoded entries in a 2-entry FIFO; count states EMPTY(0), ONE(1), FULL(2).
REQ-009 SHALL drive o_InstrReady = (count != 2), registered; a simultaneous pop in FULL does not allow a same-cycle push.
REQ-010 SHALL present an accepted instruction on outputs with o_Valid=1 after exactly one edge when the FIFO was EMPTY; throughput one instruction/cycle with i_Ready held high.
REQ-011 SHALL, on a simultaneous push and pop in ONE, stay in ONE and present the new entry next cycle.
REQ-012 SHALL keep head outputs stable while o_Valid && !i_Ready.
REQ-013 SHALL, on i_Flush, empty the FIFO on that edge; flush overrides push and pop in the same cycle.
REQ-014 SHALL decode MODE_REG: AddrReg1/2 from R1LOC_REG/R2LOC_REG; ShowRR -> ShowR1=ShowR2=1; ShowR -> ShowR1=1; ADD, AND, SUB, OR, XOR, ADC, NOT, SAR, SLR, SAL, SLL, ROL, ROR -> matching ALUOP and WriteBack=1; MOV -> ALUOP_PD2, WriteBack=1; all others -> ALUOP_PD1, WriteBack=0.
REQ-015 SHALL decode MODE_DAT (load immediate): AddrReg1 from R1LOC_DAT, AddrReg2=0, o_Imm=i_Instr[IMM_W-1:0], ImmValid=1, ALUOP_PD2, WriteBack=1, Show flags 0.
REQ-016 SHALL set o_Illegal=1, WriteBack=0, ALUOP_PD1 for MODE_REG opcodes not listed in REQ-014 except ShowR/ShowRR.
REQ-017 SHALL drive all decoded outputs to 0 whenever o_Valid=0.

Reset
REQ-018 SHALL, while i_Rst_n=0, asynchronously force count=0, o_Valid=0, o_InstrReady=0 and all decoded outputs to 0.
REQ-019 SHALL raise o_InstrReady on the first edge after reset deassertion; an instruction in flight at reset is lost.

Configuration
REQ-020 SHALL, with DECODE_PERFCNT_EN defined, add output o_DecCount [15:0] counting accepted instructions, wrapping 0xFFFF->0x0000, cleared only by reset.
REQ-021 SHALL, without DECODE_PERFCNT_EN, omit o_DecCount and its counter entirely.

Structure
REQ-022 SHALL take INSTR_MODE, MODE_REG/MODE_DAT, OPCODE_REG, OPR_*, ALUOP_*, R1LOC_*/R2LOC_* constants from the shared constants package; no local copies.
REQ-023 SHALL place the combinational opcode-to-controls mapping in sub-module decode_logic; the FIFO and handshake stay in decode_stage.

Verification
REQ-024 Reset, then REG ADD r2,r5 with i_Ready=1 -> next cycle o_Valid=1, AddrReg1=2, AddrReg2=5, ALUOp=ALUOP_ADD, WriteBack=1.
REQ-025 DAT r3, imm 0xA7 -> AddrReg1=3, o_Imm=0xA7, ImmValid=1, ALUOp=ALUOP_PD2, WriteBack=1.
REQ-026 i_Ready=0, push 3 back-to-back -> o_InstrReady=0 after 2nd; 3rd held by upstream; raise i_Ready -> 3 entries emerge in order.
REQ-027 FIFO FULL with i_Flush=1 and i_InstrValid=1 -> next cycle o_Valid=0, count 0, pushed word discarded.
REQ-028 Unlisted REG opcode -> o_Illegal=1, WriteBack=0; ShowRR -> ShowR1=ShowR2=1, WriteBack=0.
REQ-029 DECODE_PERFCNT_EN: preload 0xFFFE via 2 accepts after forcing, accept 3 -> o_DecCount wraps to 0x0001; reset mid-burst -> 0.
